// File: rtl/decoder_3to8_stream.sv
// Streaming 3-to-8 decoder: a 2-entry FIFO of codes with valid/ready on both sides,
// a one-hot view of the head entry, and a sticky mask of every delivered word.
module decoder_3to8_stream (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] in_code,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_onehot,
  output logic       out_valid,
  input  logic       out_ready,
  input  logic       clr_seen,
  output logic [7:0] seen_mask,
  output logic [1:0] occupancy
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic [1:0] state, state_next;
  logic [2:0] mem [2];
  logic       wr_ptr, rd_ptr;
  logic       accept, deliver;
  logic [2:0] head_code;

  assign head_code  = mem[rd_ptr];
  assign in_ready   = (state != FULL) && !rst;
  assign out_valid  = (state != EMPTY);
  assign out_onehot = out_valid ? (8'b1 << head_code) : 8'h00;
  assign occupancy  = state;

  assign accept  = in_valid && in_ready;
  assign deliver = out_valid && out_ready;

  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      EMPTY:   if (accept) state_next = ONE;
      ONE: begin
        if (accept && !deliver)      state_next = FULL;
        else if (deliver && !accept) state_next = EMPTY;
      end
      FULL:    if (deliver) state_next = ONE;
      default: state_next = EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      seen_mask <= 8'h00;
    end else begin
      state <= state_next;
      if (accept)  wr_ptr <= ~wr_ptr;
      if (deliver) rd_ptr <= ~rd_ptr;
      // Clear takes priority, then the word delivered on this edge is folded in.
      if (clr_seen)     seen_mask <= deliver ? out_onehot : 8'h00;
      else if (deliver) seen_mask <= seen_mask | out_onehot;
    end
  end

  // NOTE: the code storage has no reset; out_valid masks it until a code is written.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= in_code;
  end

endmodule

// File: tb/tb_decoder_3to8_stream.sv
// Directed bench for decoder_3to8_stream: a vector table of per-cycle stimulus and
// expected outputs, followed by hand-written stall, sticky-mask and reset sequences.
module tb_decoder_3to8_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] in_code;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_onehot;
  logic       out_valid;
  logic       out_ready;
  logic       clr_seen;
  logic [7:0] seen_mask;
  logic [1:0] occupancy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  decoder_3to8_stream dut (
    .clk        (clk),
    .rst        (rst),
    .in_code    (in_code),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_onehot (out_onehot),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .clr_seen   (clr_seen),
    .seen_mask  (seen_mask),
    .occupancy  (occupancy)
  );

  typedef struct {
    logic       rst;
    logic       iv;
    logic [2:0] code;
    logic       ordy;
    logic       clr;
    logic       ov;
    logic [7:0] oh;
    logic       ir;
    logic [1:0] occ;
    logic [7:0] seen;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [7:0] actual, input logic [7:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic check_all(input string tag, input logic ov, input logic [7:0] oh,
                           input logic ir, input logic [1:0] occ, input logic [7:0] seen);
    check({tag, ".out_valid"},  {7'd0, out_valid}, {7'd0, ov});
    check({tag, ".out_onehot"}, out_onehot, oh);
    check({tag, ".in_ready"},   {7'd0, in_ready}, {7'd0, ir});
    check({tag, ".occupancy"},  {6'd0, occupancy}, {6'd0, occ});
    check({tag, ".seen_mask"},  seen_mask, seen);
  endtask

  task automatic drive(input logic r, input logic iv, input logic [2:0] code,
                       input logic ordy, input logic clr);
    rst = r; in_valid = iv; in_code = code; out_ready = ordy; clr_seen = clr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //           rst  iv  code  ordy clr   ov   oh     ir   occ   seen
    vecs[0]  = '{1'b1,1'b0,3'd0,1'b0,1'b0, 1'b0,8'h00, 1'b0,2'd0, 8'h00};
    // single pass of code 5
    vecs[1]  = '{1'b0,1'b1,3'd5,1'b1,1'b0, 1'b0,8'h00, 1'b1,2'd0, 8'h00};
    vecs[2]  = '{1'b0,1'b0,3'd0,1'b1,1'b0, 1'b1,8'h20, 1'b1,2'd1, 8'h00};
    vecs[3]  = '{1'b0,1'b0,3'd0,1'b1,1'b0, 1'b0,8'h00, 1'b1,2'd0, 8'h20};
    // backpressure: 3, 6 accepted, 1 held upstream, then drained in order
    vecs[4]  = '{1'b0,1'b1,3'd3,1'b0,1'b0, 1'b0,8'h00, 1'b1,2'd0, 8'h20};
    vecs[5]  = '{1'b0,1'b1,3'd6,1'b0,1'b0, 1'b1,8'h08, 1'b1,2'd1, 8'h20};
    vecs[6]  = '{1'b0,1'b1,3'd1,1'b0,1'b0, 1'b1,8'h08, 1'b0,2'd2, 8'h20};
    vecs[7]  = '{1'b0,1'b1,3'd1,1'b1,1'b0, 1'b1,8'h08, 1'b0,2'd2, 8'h20};
    vecs[8]  = '{1'b0,1'b1,3'd1,1'b1,1'b0, 1'b1,8'h40, 1'b1,2'd1, 8'h28};
    vecs[9]  = '{1'b0,1'b0,3'd0,1'b1,1'b0, 1'b1,8'h02, 1'b1,2'd1, 8'h68};
    vecs[10] = '{1'b0,1'b0,3'd0,1'b0,1'b1, 1'b0,8'h00, 1'b1,2'd0, 8'h6A};
    // simultaneous accept and deliver while ONE
    vecs[11] = '{1'b0,1'b1,3'd2,1'b0,1'b0, 1'b0,8'h00, 1'b1,2'd0, 8'h00};
    vecs[12] = '{1'b0,1'b1,3'd7,1'b1,1'b0, 1'b1,8'h04, 1'b1,2'd1, 8'h00};
    vecs[13] = '{1'b0,1'b0,3'd0,1'b0,1'b0, 1'b1,8'h80, 1'b1,2'd1, 8'h04};
    vecs[14] = '{1'b0,1'b0,3'd0,1'b1,1'b0, 1'b1,8'h80, 1'b1,2'd1, 8'h04};
    vecs[15] = '{1'b0,1'b0,3'd0,1'b0,1'b1, 1'b0,8'h00, 1'b1,2'd0, 8'h84};

    drive(1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    tick();
    tick();

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].rst, vecs[i].iv, vecs[i].code, vecs[i].ordy, vecs[i].clr);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].ov, vecs[i].oh, vecs[i].ir,
                vecs[i].occ, vecs[i].seen);
      tick();
    end
    check_all("vec_end", 1'b0, 8'h00, 1'b1, 2'd0, 8'h00);

    // Stall: head code 0 held for 5 cycles with out_ready low
    drive(1'b0, 1'b1, 3'd0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("stall%0d.out_onehot", i), out_onehot, 8'h01);
      check($sformatf("stall%0d.out_valid", i), {7'd0, out_valid}, 8'h01);
      tick();
    end
    drive(1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
    tick();
    check_all("stall_done", 1'b0, 8'h00, 1'b1, 2'd0, 8'h01);

    // Sticky mask: stream 0, 4, 4, 7 at full rate
    drive(1'b0, 1'b1, 3'd0, 1'b1, 1'b0); tick();
    drive(1'b0, 1'b1, 3'd4, 1'b1, 1'b0); tick();
    drive(1'b0, 1'b1, 3'd4, 1'b1, 1'b0); tick();
    check("sticky.mid_occupancy", {6'd0, occupancy}, 8'h01);
    drive(1'b0, 1'b1, 3'd7, 1'b1, 1'b0); tick();
    drive(1'b0, 1'b0, 3'd0, 1'b1, 1'b0); tick();
    check_all("sticky", 1'b0, 8'h00, 1'b1, 2'd0, 8'h91);
    // clear and deliver code 1 on the same edge
    drive(1'b0, 1'b1, 3'd1, 1'b0, 1'b0); tick();
    drive(1'b0, 1'b0, 3'd0, 1'b1, 1'b1); tick();
    drive(1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    check_all("clr_deliver", 1'b0, 8'h00, 1'b1, 2'd0, 8'h02);

    // Reset with the buffer full; out_ready high must not deliver on the reset edge
    drive(1'b0, 1'b1, 3'd5, 1'b0, 1'b0); tick();
    drive(1'b0, 1'b1, 3'd6, 1'b0, 1'b0); tick();
    drive(1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    check_all("pre_reset", 1'b1, 8'h20, 1'b0, 2'd2, 8'h02);
    drive(1'b1, 1'b1, 3'd3, 1'b1, 1'b0);
    #1;
    check("in_reset.in_ready", {7'd0, in_ready}, 8'h00);
    tick();
    drive(1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    #1;
    check_all("post_reset", 1'b0, 8'h00, 1'b1, 2'd0, 8'h00);
    // Buffer must be empty, not holding stale codes: a new code appears next
    drive(1'b0, 1'b1, 3'd4, 1'b1, 1'b0); tick();
    drive(1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
    check_all("post_reset_pass", 1'b1, 8'h10, 1'b1, 2'd1, 8'h00);
    tick();
    check_all("post_reset_drain", 1'b0, 8'h00, 1'b1, 2'd0, 8'h10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decoder_3to8_stream.md
DECODER_3TO8_STREAM -- requirements
Module: decoder_3to8_stream

Interface
REQ-001 Parameters: none; code width fixed at 3, output width fixed at 8.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_code  input  3  encoded index (0..7) from upstream priority encoder.
REQ-005 in_valid  input  1  in_code valid this cycle.
REQ-006 in_ready  output  1  block can accept a code this cycle.
REQ-007 out_onehot  output  8  decoded one-hot of buffer head; bit in_code set.
REQ-008 out_valid  output  1  out_onehot valid this cycle.
REQ-009 out_ready  input  1  downstream accepts out_onehot this cycle.
REQ-010 clr_seen  input  1  synchronous clear of seen_mask.
REQ-011 seen_mask  output  8  sticky OR of all one-hot words delivered since last clear/reset.
REQ-012 occupancy  output  2  number of buffered entries (0, 1, 2).

Function
REQ-013 Accept = in_valid && in_ready at a rising edge; deliver = out_valid && out_ready at a rising edge.
REQ-014 Buffer: 2-entry FIFO of 3-bit codes; strict arrival order; no code dropped, duplicated or reordered.
REQ-015 State machine on occupancy: EMPTY(0), ONE(1), FULL(2); registered.
REQ-016 EMPTY: accept -> ONE; otherwise stay.
REQ-017 ONE: accept only -> FULL; deliver only -> EMPTY; accept and deliver same edge -> stay ONE, head replaced by new code.
REQ-018 FULL: deliver -> ONE (second entry becomes head); no accept possible.
REQ-019 in_ready = 1 iff occupancy < 2 and rst = 0; in_ready has no combinational path from out_ready or in_valid.
REQ-020 out_valid = 1 iff occupancy > 0; driven from registers only.
REQ-021 out_onehot = 8'b1 << head_code when out_valid = 1; 8'h00 when out_valid = 0.
REQ-022 Latency: code accepted at edge k appears on out_onehot/out_valid in the cycle after edge k when buffer was EMPTY; otherwise after all earlier entries are delivered.
REQ-023 Throughput: one accept and one deliver per cycle sustained when out_ready held high.
REQ-024 out_onehot and head shall remain stable while out_valid = 1 and out_ready = 0.
REQ-025 seen_mask on each deliver: seen_mask <= seen_mask | out_onehot.
REQ-026 clr_seen and deliver same edge: seen_mask <= out_onehot (clear first, then set); clr_seen alone: seen_mask <= 8'h00.
REQ-027 in_code values are all legal; in_code ignored when not accepted.

Reset
REQ-028 While rst = 1 at an edge: occupancy <= 0, FIFO pointers <= 0, seen_mask <= 8'h00; in_valid, out_ready, clr_seen ignored.
REQ-029 Output values after reset edge: out_valid = 0, out_onehot = 8'h00, occupancy = 0, seen_mask = 8'h00, in_ready = 1 once rst = 0.
REQ-030 Reset mid-operation discards all buffered codes; no delivery occurs on the reset edge.

Verification
REQ-031 Single pass: out_ready = 1, send in_code = 5 -> next cycle out_onehot = 8'h20, out_valid = 1; following cycle out_valid = 0, seen_mask = 8'h20.
REQ-032 Backpressure: out_ready = 0, send codes 3, 6, then 1 -> first two accepted, in_ready = 0 and occupancy = 2, code 1 held upstream; raise out_ready -> outputs 8'h08, 8'h40, 8'h02 in order.
REQ-033 Simultaneous in ONE: head code 2, out_ready = 1, in_code = 7 valid -> occupancy stays 1, next out_onehot = 8'h80.
REQ-034 Stall stability: out_ready = 0 for 5 cycles with head code 0 -> out_onehot = 8'h01 constant, out_valid = 1 throughout.
REQ-035 Sticky mask: deliver 0, 4, 4, 7 -> seen_mask = 8'h91; clr_seen with delivery of code 1 same edge -> seen_mask = 8'h02.
REQ-036 Reset mid-stream: occupancy = 2, assert rst one cycle -> out_valid = 0, out_onehot = 8'h00, seen_mask = 8'h00, occupancy = 0, in_ready = 1 after rst drops.
